muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; legal values are even and at least 8.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1: iteration counter width.
REQ-003 clk  in  1  sole clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  in  1  operation request; sampled only while busy=0.
REQ-006 op  in  3  operation code, md_op_t.
REQ-007 srca  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo data.
REQ-008 srcb  in  WIDTH  rt operand: multiplier or divisor.
REQ-009 abort  in  1  pipeline flush; cancels an in-flight operation.
REQ-010 busy  out  1  operation in progress; the hazard unit stalls mfhi/mflo and new mult/div on busy=1.
REQ-011 done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 hi  out  WIDTH  architectural HI register.
REQ-013 lo  out  WIDTH  architectural LO register.

Function
REQ-014 md_op_t encodings SHALL be: MULT 3'd0, MULTU 3'd1, DIV 3'd2, DIVU 3'd3, MTHI 3'd4, MTLO 3'd5; codes 6 and 7 SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, CALC and FIN, with busy=1 exactly in CALC and FIN.
REQ-016 In IDLE with start=1 and op MULT, MULTU, DIV or DIVU, the FSM SHALL latch absolute or raw operands plus sign flags, clear the counter, and go to CALC on that edge.
REQ-017 In IDLE with start=1 and op MTHI or MTLO, hi or lo SHALL load srca on that edge; the FSM stays in IDLE, busy stays 0, done stays 0.
REQ-018 start SHALL be ignored while busy=1; a queued request is never accepted.
REQ-019 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-020 CALC SHALL last exactly WIDTH cycles, then move to FIN.
REQ-021 FIN SHALL apply sign correction and write HI/LO, then return to IDLE with done=1 for one cycle.
REQ-022 With start sampled at edge E0, done and the new HI/LO SHALL be visible after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
REQ-023 Multiply: {hi,lo} SHALL equal the 2*WIDTH-bit product; MULT is signed two's complement, MULTU unsigned.
REQ-024 Divide: lo SHALL hold the quotient truncated toward zero, and hi SHALL hold a remainder carrying the dividend's sign.
REQ-025 Divide by zero (DIV or DIVU) SHALL give lo = all ones and hi = srca, with the same latency; no exception is raised.
REQ-026 DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-027 abort=1 in CALC or FIN SHALL force IDLE on that edge, leave hi/lo unchanged, and produce no done pulse.
REQ-028 abort=1 in IDLE SHALL also suppress a simultaneous start, including MTHI/MTLO.
REQ-029 hi and lo SHALL change only through REQ-017 or REQ-021.

Reset
REQ-030 While reset=0 at a rising edge, the FSM SHALL go to IDLE, and busy, done, hi, lo and the counter SHALL all become 0.
REQ-031 Reset SHALL take priority over start and abort.
REQ-032 Reset mid-operation SHALL discard the operation without a done pulse.

Structure
REQ-033 Package muldiv_pkg SHALL hold md_op_t, the FSM state enum and the op encodings; the hazard unit and controller import it.
REQ-034 The divide datapath SHALL be a sub-module, div_step, that is combinational: one restoring iteration (remainder, quotient, divisor in; next remainder and quotient out).
REQ-035 The multiply step SHALL stay inline.
REQ-036 All storage SHALL be flip-flops on clk.
REQ-037 The unit SHALL contain no combinational path from start to busy.

Verification (WIDTH=32)
REQ-038 MULT, srca=-3, srcb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done seen exactly 33 edges after start.
REQ-039 MULTU, srca=srcb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 DIV, srca=-7, srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 DIVU, srca=100, srcb=0 -> lo=0xFFFFFFFF, hi=100.
REQ-042 Abort case: MTHI 0x1234 then MTLO 0x5678; start MULT 7*9; abort at edge E10 -> busy=0 after E10, no done, hi=0x1234, lo=0x5678.
REQ-043 Start-while-busy case: start MULT 2*3, pulse start DIVU 9/3 at E5 -> ignored, lo=6, hi=0.
REQ-044 Reset case: drive reset=0 for one edge at E20 -> hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply-divide unit: operation codes, FSM states
// and small opcode classifiers used by the controller and the hazard unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } md_state_t;

    function automatic logic op_is_muldiv(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign fits    = (shifted >= {1'b0, divisor});

    // The partial remainder stays below the divisor, so the kept result fits WIDTH bits.
    always_comb begin
        rem_next = fits ? WIDTH'(trial) : WIDTH'(shifted);
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, with sign correction applied in a final cycle before HI/LO update.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | waiting; accepts mult/div (-> CALC) and mthi/mtlo (stay)
//  ST_CALC | WIDTH radix-2 iterations, counter tracks step number
//  ST_FIN  | sign correction, HI/LO write, done pulse, back to IDLE
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state, state_nx;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] rem_q, quo_q, opnd_b;
    logic             is_div, neg_q, neg_r, div_zero;

    logic             req;
    logic             last_step;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign req       = (state == ST_IDLE) && start && !abort;
    assign last_step = (cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (req && op_is_muldiv(op)) state_nx = ST_CALC;
            ST_CALC: if (abort) state_nx = ST_IDLE;
                     else if (last_step) state_nx = ST_FIN;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    assign neg_a = op_is_signed(op) && srca[WIDTH-1];
    assign neg_b = op_is_signed(op) && srcb[WIDTH-1];
    assign abs_a = neg_a ? -srca : srca;
    assign abs_b = neg_b ? -srcb : srcb;

    // Multiply: rem_q is the running high half, quo_q shifts the multiplier out.
    assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_b} : '0);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (opnd_b),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

    assign prod     = {rem_q, quo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = div_zero ? '1 : (neg_q ? -quo_q : quo_q);
    assign rem_fix  = neg_r ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            opnd_b   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: if (req) begin
                    if (op_is_muldiv(op)) begin
                        cnt      <= '0;
                        rem_q    <= '0;
                        is_div   <= op_is_div(op);
                        neg_q    <= neg_a ^ neg_b;
                        neg_r    <= op_is_div(op) && neg_a;
                        div_zero <= op_is_div(op) && (srcb == '0);
                        // Multiply iterates over the multiplier, divide over the dividend.
                        quo_q    <= op_is_div(op) ? abs_a : abs_b;
                        opnd_b   <= op_is_div(op) ? abs_b : abs_a;
                    end else if (op == MD_MTHI) begin
                        hi <= srca;
                    end else if (op == MD_MTLO) begin
                        lo <= srca;
                    end
                end
                ST_CALC: if (!abort) begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem_q <= div_rem;
                        quo_q <= div_quo;
                    end else begin
                        rem_q <= mul_sum[WIDTH:1];
                        quo_q <= {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                end
                ST_FIN: if (!abort) begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus
// random operations compared against an arithmetic HI/LO reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] srca, srcb;
    logic             abort;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl_hi, mdl_lo;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted operation on HI/LO.
    task automatic model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sq, sr;
        longint unsigned up;
        case (opc)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                mdl_hi = sp[63:32];
                mdl_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                mdl_hi = up[63:32];
                mdl_lo = up[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    mdl_lo = '1;
                    mdl_hi = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    mdl_lo = sq[31:0];
                    mdl_hi = sr[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    mdl_lo = '1;
                    mdl_hi = a;
                end else begin
                    mdl_lo = a / b;
                    mdl_hi = a % b;
                end
            end
            3'd4: mdl_hi = a;
            3'd5: mdl_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request at the next edge and check result, latency and handshake.
    task automatic run_op(input string tag, input logic [2:0] opc, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        start = 1'b1;
        op    = md_op_t'(opc);
        srca  = a;
        srcb  = b;
        tick();
        start = 1'b0;
        model(opc, a, b);
        if (opc <= 3'd3) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            lat = 0;
            for (int n = 1; n <= LAT + 8; n++) begin
                tick();
                if (done) begin
                    lat = n;
                    break;
                end
            end
            check({tag, "_lat"}, 64'(lat), 64'(LAT));
            check({tag, "_busy_end"}, 64'(busy), 64'd0);
        end else begin
            check({tag, "_busy"}, 64'(busy), 64'd0);
            check({tag, "_done"}, 64'(done), 64'd0);
        end
        check({tag, "_hi"}, 64'(hi), 64'(mdl_hi));
        check({tag, "_lo"}, 64'(lo), 64'(mdl_lo));
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (done) seen++;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  ropc;
        logic [31:0] ra, rb;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op    = MD_MULT;
        srca  = '0;
        srcb  = '0;
        tick();
        tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        mdl_hi = '0;
        mdl_lo = '0;
        tick();

        run_op("mult_m3x5", 3'd0, -32'sd3, 32'd5);
        check("mult_m3x5_hi_k", 64'(hi), 64'hFFFF_FFFF);
        check("mult_m3x5_lo_k", 64'(lo), 64'hFFFF_FFF1);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_k", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_k", 64'(lo), 64'h0000_0001);
        run_op("div_m7d2", 3'd2, -32'sd7, 32'd2);
        check("div_m7d2_lo_k", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7d2_hi_k", 64'(hi), 64'hFFFF_FFFF);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1_lo_k", 64'(lo), 64'h8000_0000);
        check("div_min_m1_hi_k", 64'(hi), 64'h0);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0);
        check("divu_by0_lo_k", 64'(lo), 64'hFFFF_FFFF);
        check("divu_by0_hi_k", 64'(hi), 64'd100);
        run_op("div_neg_by0", 3'd2, -32'sd9, 32'd0);

        // Abort mid-calculation at E10.
        run_op("mthi", 3'd4, 32'h1234, 32'd0);
        run_op("mtlo", 3'd5, 32'h5678, 32'd0);
        start = 1'b1; op = MD_MULT; srca = 32'd7; srcb = 32'd9;
        tick();
        start = 1'b0;
        for (int n = 1; n < 10; n++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        watch_no_done("abort", LAT + 5);
        check("abort_hi", 64'(hi), 64'h1234);
        check("abort_lo", 64'(lo), 64'h5678);

        // Abort in IDLE suppresses an mthi issued on the same edge.
        start = 1'b1; abort = 1'b1; op = MD_MTHI; srca = 32'hDEAD;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_hi", 64'(hi), 64'h1234);
        check("idle_abort_busy", 64'(busy), 64'd0);

        // Codes 6 and 7 do nothing.
        run_op("op6", 3'd6, 32'hAAAA, 32'd1);
        run_op("op7", 3'd7, 32'hBBBB, 32'd1);

        // Start while busy is ignored and never queued.
        start = 1'b1; op = MD_MULT; srca = 32'd2; srcb = 32'd3;
        tick();
        start = 1'b0;
        for (int n = 1; n < 5; n++) tick();
        start = 1'b1; op = MD_DIVU; srca = 32'd9; srcb = 32'd3;
        tick();
        start = 1'b0;
        begin
            int lat = 0;
            for (int n = 6; n <= LAT + 8; n++) begin
                tick();
                if (done) begin
                    lat = n;
                    break;
                end
            end
            check("busy_start_lat", 64'(lat), 64'(LAT));
        end
        check("busy_start_lo", 64'(lo), 64'd6);
        check("busy_start_hi", 64'(hi), 64'd0);
        watch_no_done("busy_start_queue", LAT + 5);
        mdl_hi = 32'd0;
        mdl_lo = 32'd6;

        // Reset mid-operation at E20.
        run_op("pre_rst_mthi", 3'd4, 32'hCAFE, 32'd0);
        start = 1'b1; op = MD_DIV; srca = 32'd1000; srcb = 32'd7;
        tick();
        start = 1'b0;
        for (int n = 1; n < 20; n++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        watch_no_done("midrst", LAT + 5);
        mdl_hi = '0;
        mdl_lo = '0;

        for (int i = 0; i < 60; i++) begin
            ropc = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'd0;
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
                4: begin ra = -32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, ropc), ropc, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
